frame_rx_d64: RTL

- Byte-stream deframer sitting directly upstream of the redundant comparison stage. One instance per input channel.
- Hunts for a start-of-frame (SOF) byte, assembles 8 payload bytes (MSB first) into a 64-bit word, and validates a trailing XOR checksum byte.
- On a valid frame it presents the word with a one-cycle enable pulse, matching the compare stage's dataIn/dataEn input contract.
- Malformed or stalled frames are dropped, flagged with an error pulse, and counted.

---
 rtl/frame_rx_d64.sv | 133 +++++++++++++
 1 files changed

// File: rtl/frame_rx_d64.sv
// frame_rx_d64: byte-stream deframer for one input channel.
//   Hunts for an SOF byte, shifts in 8 payload bytes (MSB first) and checks
//   a trailing XOR checksum. A good frame updates dataOut with a one-cycle
//   dataEn pulse. A bad checksum or an over-long inter-byte gap drops the
//   frame with a one-cycle frmErr pulse and bumps a saturating error count.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   byteIn     received byte, qualified by byteValid
//   byteValid  one byte accepted per cycle when high
//   dataOut    last good 64-bit payload (first byte in [63:56])
//   dataEn     one-cycle pulse, dataOut newly updated
//   frmErr     one-cycle pulse, frame dropped
//   errCnt     saturating count of dropped frames
//   busy       registered, high while a frame is in progress
module frame_rx_d64 #(
  parameter logic [7:0]  SOF     = 8'hAA,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic [63:0] dataOut,
  output logic        dataEn,
  output logic        frmErr,
  output logic [7:0]  errCnt,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;

  // Abort fires on the TIMEOUT-th consecutive idle cycle, i.e. when the
  // counter has already seen TIMEOUT-1 idle cycles.
  localparam logic [15:0] GAP_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q,   idx_d;
  logic [7:0]  acc_q,   acc_d;
  logic [63:0] shift_q, shift_d;
  logic [15:0] gap_q,   gap_d;
  logic [63:0] data_q,  data_d;
  logic        en_q,    en_d;
  logic        err_q,   err_d;
  logic [7:0]  cnt_q,   cnt_d;
  logic        busy_q,  busy_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    shift_d = shift_q;
    gap_d   = gap_q;
    data_d  = data_q;
    en_d    = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        gap_d = '0;
        if (byteValid && byteIn == SOF) begin
          state_d = PAYLOAD;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      PAYLOAD, CHECK: begin
        if (byteValid) begin
          // An arriving byte always beats the timeout.
          gap_d = '0;
          if (state_q == PAYLOAD) begin
            shift_d = {shift_q[55:0], byteIn};
            acc_d   = acc_q ^ byteIn;
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = CHECK;
          end else begin
            state_d = IDLE;
            if (byteIn == acc_q) begin
              data_d = shift_q;
              en_d   = 1'b1;
            end else begin
              err_d  = 1'b1;
            end
          end
        end else if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          gap_d   = '0;
          err_d   = 1'b1;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (err_d && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      shift_q <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      shift_q <= shift_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      en_q    <= en_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign dataOut = data_q;
  assign dataEn  = en_q;
  assign frmErr  = err_q;
  assign errCnt  = cnt_q;
  assign busy    = busy_q;

endmodule
